// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter and sequencer for one shared 4-bit logic unit (OR/AND/XOR/NOR).
// Optional accepted-request counter enabled by defining ARB_GRANT_COUNT_EN.
module logic_unit_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [4*N-1:0]   req_x,
  input  logic [4*N-1:0]   req_y,
  input  logic [2*N-1:0]   req_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [3:0]       resp_z,
  output logic [IDW-1:0]   resp_id,
  output logic             busy,
  output logic [15:0]      grant_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant_idx;
  logic           grant_hit;
  logic           grant_fire;
  logic [3:0]     sel_x;
  logic [3:0]     sel_y;
  logic [1:0]     sel_op;
  logic [3:0]     alu_z;

  // Index k places after base, wrapped into 0..N-1.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
    return IDW'((int'(base) + k) % N);
  endfunction

  // Search begins one past the previous winner, so last_grant=N-1 wraps to 0.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= N; k++) begin
      if (!grant_hit && req_valid[rr_index(last_grant, k)]) begin
        grant_hit = 1'b1;
        grant_idx = rr_index(last_grant, k);
      end
    end
  end

  // Outputs must read zero while rst_n is low, including this combinational one.
  assign grant_fire = rst_n && (state == IDLE) && grant_hit;

  always_comb begin
    req_ready = '0;
    if (grant_fire) req_ready[grant_idx] = 1'b1;
  end

  // Only the winner's operands reach the datapath.
  always_comb begin
    sel_x  = '0;
    sel_y  = '0;
    sel_op = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_x  = req_x[4*i +: 4];
        sel_y  = req_y[4*i +: 4];
        sel_op = req_op[2*i +: 2];
      end
    end
  end

  always_comb begin
    unique case (op_t'(sel_op))
      OP_OR:   alu_z = sel_x | sel_y;
      OP_AND:  alu_z = sel_x & sel_y;
      OP_XOR:  alu_z = sel_x ^ sel_y;
      OP_NOR:  alu_z = ~(sel_x | sel_y);
      default: alu_z = '0;
    endcase
  end

  // resp_ready is ignored in IDLE, so an accept can only land from the cycle after the grant.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDW'(N - 1);
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      resp_z     <= '0;
      resp_id    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_fire) begin
            resp_z     <= alu_z;
            resp_id    <= grant_idx;
            last_grant <= grant_idx;
            resp_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_GRANT_COUNT_EN
  // Saturating count of accepted requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_count <= '0;
    end else if (grant_fire && (grant_count != 16'hFFFF)) begin
      grant_count <= grant_count + 16'd1;
    end
  end
`else
  assign grant_count = 16'h0000;
`endif

endmodule
